// File: rtl/snn_pkg.sv
// snn_pkg: shared types and constants for the LIF SNN core.
//   sched_state_t : state encoding of the weight-memory scheduler
//   NUM_ROWS_DEF  : default number of weight rows (input spike channels)
//   NUM_STEPS_DEF : default number of timesteps per inference
//   ADDR_W/STEP_W : row-address and timestep-counter widths for the defaults
package snn_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_SPK,
    SCAN,
    FETCH,
    LOAD,
    ACC,
    FIRE,
    DONE
  } sched_state_t;

  localparam int NUM_ROWS_DEF  = 16;
  localparam int NUM_STEPS_DEF = 8;
  localparam int ADDR_W        = $clog2(NUM_ROWS_DEF);
  localparam int STEP_W        = $clog2(NUM_STEPS_DEF);

endpackage

// File: rtl/snn_weight_sched.sv
// snn_weight_sched: per-timestep scheduler for the weight-memory stage.
// Latches one spike vector per timestep, walks the weight rows (fetch from
// ROM, load into weight memory, accumulate), then issues the neuron
// leak/fire update. After NUM_STEPS timesteps it pulses done.
//
// Ports:
//   clk, rst             single clock, synchronous active-high reset
//   start                begin inference (only honoured in IDLE)
//   spike_valid/vec      spike vector for the current timestep
//   spike_ready          vector accepted (WAIT_SPK only)
//   row_req/row_addr     weight-row fetch request and row index
//   row_ack              row data available this cycle
//   wemem_enable         weight-memory load enable
//   we_done              weight memory holds the row
//   acc_en               neurons accumulate weight_out this cycle
//   fire_en              neuron leak/fire update pulse
//   busy, done, step_cnt status
//
// Build option: define SNN_SKIP_ZERO_SPIKE_EN to skip rows whose spike bit
// is 0 (only spiking rows are fetched). Without it every row is fetched and
// acc_en is gated by the spike bit.
module snn_weight_sched
  import snn_pkg::*;
#(
  parameter int NUM_ROWS  = NUM_ROWS_DEF,
  parameter int NUM_STEPS = NUM_STEPS_DEF
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic                         spike_valid,
  input  logic [NUM_ROWS-1:0]          spike_vec,
  output logic                         spike_ready,
  output logic                         row_req,
  output logic [$clog2(NUM_ROWS)-1:0]  row_addr,
  input  logic                         row_ack,
  output logic                         wemem_enable,
  input  logic                         we_done,
  output logic                         acc_en,
  output logic                         fire_en,
  output logic                         busy,
  output logic                         done,
  output logic [$clog2(NUM_STEPS)-1:0] step_cnt
);

  localparam int AW = $clog2(NUM_ROWS);
  localparam int SW = $clog2(NUM_STEPS);

  sched_state_t        state_reg, state_next;
  logic [NUM_ROWS-1:0] spike_reg, spike_next;
  logic [AW-1:0]       row_idx_reg, row_idx_next;
  logic [SW-1:0]       step_cnt_reg, step_cnt_next;

  // Terminal compares drive the transitions, so the counters never wrap.
  logic last_row;
  logic last_step;
  logic row_spike;

  assign last_row  = (row_idx_reg == AW'(NUM_ROWS - 1));
  assign last_step = (step_cnt_reg == SW'(NUM_STEPS - 1));
  assign row_spike = spike_reg[row_idx_reg];

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= IDLE;
      spike_reg    <= '0;
      row_idx_reg  <= '0;
      step_cnt_reg <= '0;
    end else begin
      state_reg    <= state_next;
      spike_reg    <= spike_next;
      row_idx_reg  <= row_idx_next;
      step_cnt_reg <= step_cnt_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    spike_next    = spike_reg;
    row_idx_next  = row_idx_reg;
    step_cnt_next = step_cnt_reg;
    spike_ready   = 1'b0;
    row_req       = 1'b0;
    row_addr      = '0;
    wemem_enable  = 1'b0;
    acc_en        = 1'b0;
    fire_en       = 1'b0;
    done          = 1'b0;

    case (state_reg)
      IDLE: begin
        if (start) begin
          step_cnt_next = '0;
          state_next    = WAIT_SPK;
        end
      end
      WAIT_SPK: begin
        spike_ready = 1'b1;
        if (spike_valid) begin
          spike_next   = spike_vec;
          row_idx_next = '0;
          state_next   = SCAN;
        end
      end
      SCAN: begin
`ifdef SNN_SKIP_ZERO_SPIKE_EN
        if (row_spike) begin
          state_next = FETCH;
        end else if (last_row) begin
          state_next = FIRE;
        end else begin
          row_idx_next = row_idx_reg + AW'(1);
        end
`else
        state_next = FETCH;
`endif
      end
      FETCH: begin
        row_req  = 1'b1;
        row_addr = row_idx_reg;
        if (row_ack) state_next = LOAD;
      end
      LOAD: begin
        wemem_enable = 1'b1;
        if (we_done) state_next = ACC;
      end
      ACC: begin
        // Enable stays high so weight_out remains valid while accumulating.
        wemem_enable = 1'b1;
        acc_en       = row_spike;
        if (last_row) begin
          state_next = FIRE;
        end else begin
          row_idx_next = row_idx_reg + AW'(1);
          state_next   = SCAN;
        end
      end
      FIRE: begin
        fire_en = 1'b1;
        if (last_step) begin
          state_next = DONE;
        end else begin
          step_cnt_next = step_cnt_reg + SW'(1);
          state_next    = WAIT_SPK;
        end
      end
      DONE: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign busy     = (state_reg != IDLE);
  assign step_cnt = step_cnt_reg;

endmodule

// File: tb/tb_snn_weight_sched.sv
// tb_snn_weight_sched: directed bench for snn_weight_sched with two
// timesteps per inference, a ROM model with programmable row_ack delay and
// a weight-memory model that raises we_done one cycle after enable.
// Expected values follow SNN_SKIP_ZERO_SPIKE_EN when it is defined.
module tb_snn_weight_sched;
  import snn_pkg::*;

  localparam int NR = NUM_ROWS_DEF;
  localparam int NS = 2;
  localparam int SW = $clog2(NS);

  // Expected per-inference figures (2 steps). Cycle counts per visited row
  // with immediate ack: SCAN 1 + FETCH 1 + LOAD 2 + ACC 1 = 5; with a
  // 3-cycle ack delay FETCH takes 4, so 8. Latency is measured from the
  // spike-accept cycle to the FIRE cycle of the last step.
`ifdef SNN_SKIP_ZERO_SPIKE_EN
  localparam int A_FETCH = 4,  A_WE = 12, A_LAT = 25, A_RUN = 1;
  localparam int Z_FETCH = 0,  Z_WE = 0,  Z_LAT = 17, Z_RUN = 0;
  localparam int D_FETCH = 2,  D_WE = 6,  D_LAT = 24, D_RUN = 4;
`else
  localparam int A_FETCH = 32, A_WE = 96, A_LAT = 81,  A_RUN = 1;
  localparam int Z_FETCH = 32, Z_WE = 96, Z_LAT = 81,  Z_RUN = 1;
  localparam int D_FETCH = 32, D_WE = 96, D_LAT = 129, D_RUN = 4;
`endif

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic              spike_valid;
  logic [NR-1:0]     spike_vec;
  logic              spike_ready;
  logic              row_req;
  logic [ADDR_W-1:0] row_addr;
  logic              row_ack;
  logic              wemem_enable;
  logic              we_done = 1'b0;
  logic              acc_en;
  logic              fire_en;
  logic              busy;
  logic              done;
  logic [SW-1:0]     step_cnt;

  snn_weight_sched #(.NUM_ROWS(NR), .NUM_STEPS(NS)) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .spike_valid  (spike_valid),
    .spike_vec    (spike_vec),
    .spike_ready  (spike_ready),
    .row_req      (row_req),
    .row_addr     (row_addr),
    .row_ack      (row_ack),
    .wemem_enable (wemem_enable),
    .we_done      (we_done),
    .acc_en       (acc_en),
    .fire_en      (fire_en),
    .busy         (busy),
    .done         (done),
    .step_cnt     (step_cnt)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ROM model: acknowledges after ack_delay cycles of continuous request.
  int ack_delay = 0;
  int req_cnt = 0;
  assign row_ack = row_req && (req_cnt == ack_delay);
  always @(posedge clk) begin
    if (rst || !row_req || row_ack) req_cnt <= 0;
    else req_cnt <= req_cnt + 1;
  end

  // Weight-memory model: row held one cycle after enable.
  always @(posedge clk) we_done <= rst ? 1'b0 : wemem_enable;

  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Event monitor, sampled mid-cycle.
  int n_accept, n_fire, n_done, n_fetch, n_acc, n_we;
  int acc_cyc, fire_cyc, done_cyc, fire_lat, fire_steps;
  int req_run, max_req_run, req_addr_bad, req_we_bad;
  logic [NR-1:0]     acc_mask;
  logic [ADDR_W-1:0] last_addr;

  task automatic clear_stats();
    n_accept = 0; n_fire = 0; n_done = 0; n_fetch = 0; n_acc = 0; n_we = 0;
    acc_cyc = 0; fire_cyc = 0; done_cyc = 0; fire_lat = 0; fire_steps = 0;
    req_run = 0; max_req_run = 0; req_addr_bad = 0; req_we_bad = 0;
    acc_mask = '0; last_addr = '0;
  endtask

  always @(negedge clk) begin
    if (spike_ready && spike_valid) begin
      n_accept++;
      acc_cyc = cyc;
    end
    if (row_req) begin
      if (req_run > 0 && row_addr != last_addr) req_addr_bad++;
      if (wemem_enable) req_we_bad++;
      req_run++;
      last_addr = row_addr;
      if (row_ack) begin
        n_fetch++;
        if (req_run > max_req_run) max_req_run = req_run;
      end
    end else begin
      req_run = 0;
    end
    if (wemem_enable) n_we++;
    if (acc_en) begin
      n_acc++;
      acc_mask[last_addr] = 1'b1;
    end
    if (fire_en) begin
      n_fire++;
      fire_lat = cyc - acc_cyc;
      fire_cyc = cyc;
      fire_steps |= (1 << step_cnt);
    end
    if (done) begin
      n_done++;
      done_cyc = cyc;
    end
  end

  task automatic pulse_start();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  // One full inference; returns in the mid-cycle of the DONE cycle.
  task automatic run_test(input string tag, input logic [NR-1:0] vec,
                          input int delay, input int exp_fetch, input int exp_acc,
                          input int exp_we, input int exp_lat, input int exp_run,
                          input logic [NR-1:0] exp_mask, input bit poke_start);
    int budget;
    clear_stats();
    ack_delay   = delay;
    spike_vec   = vec;
    spike_valid = 1'b1;
    pulse_start();
    budget = 0;
    while (n_done == 0 && budget < 3000) begin
      @(negedge clk); #1;
      start = poke_start && busy && (budget % 37 == 5);
      budget++;
    end
    start = 1'b0;
    if (n_done == 0) check({tag, ".timeout"}, 0, 1);
    check({tag, ".accepts"}, n_accept, NS);
    check({tag, ".fires"}, n_fire, NS);
    check({tag, ".dones"}, n_done, 1);
    check({tag, ".fire_steps"}, fire_steps, 3);
    check({tag, ".done_after_fire"}, done_cyc - fire_cyc, 1);
    check({tag, ".fetches"}, n_fetch, exp_fetch);
    check({tag, ".acc_pulses"}, n_acc, exp_acc);
    check({tag, ".acc_rows"}, int'(acc_mask), int'(exp_mask));
    check({tag, ".we_cycles"}, n_we, exp_we);
    check({tag, ".fire_latency"}, fire_lat, exp_lat);
    check({tag, ".req_run"}, max_req_run, exp_run);
    check({tag, ".req_addr_unstable"}, req_addr_bad, 0);
    check({tag, ".we_during_req"}, req_we_bad, 0);
    $display("txn %s vec=%h delay=%0d fetch=%0d acc=%0d we=%0d lat=%0d",
             tag, vec, delay, n_fetch, n_acc, n_we, fire_lat);
  endtask

  task automatic check_idle(input string tag);
    @(negedge clk); #1;
    check({tag, ".idle_busy"}, int'(busy), 0);
    check({tag, ".idle_done"}, int'(done), 0);
  endtask

  initial begin
    int budget;
    clear_stats();
    rst = 1'b1; start = 1'b0; spike_valid = 1'b0; spike_vec = '0;
    repeat (3) @(posedge clk);
    @(negedge clk); #1;
    check("rst.busy", int'(busy), 0);
    check("rst.done", int'(done), 0);
    check("rst.fire_en", int'(fire_en), 0);
    check("rst.row_req", int'(row_req), 0);
    check("rst.row_addr", int'(row_addr), 0);
    check("rst.wemem_enable", int'(wemem_enable), 0);
    check("rst.acc_en", int'(acc_en), 0);
    check("rst.spike_ready", int'(spike_ready), 0);
    check("rst.step_cnt", int'(step_cnt), 0);
    $display("txn reset busy=%0d step_cnt=%0d", busy, step_cnt);
    rst = 1'b0;

    run_test("sparse", 16'h0005, 0, A_FETCH, 4, A_WE, A_LAT, A_RUN, 16'h0005, 1'b0);
    check_idle("sparse");
    run_test("zero", 16'h0000, 0, Z_FETCH, 0, Z_WE, Z_LAT, Z_RUN, 16'h0000, 1'b0);
    check_idle("zero");
    run_test("ackdly", 16'h0001, 3, D_FETCH, 2, D_WE, D_LAT, D_RUN, 16'h0001, 1'b0);
    check_idle("ackdly");

    // Abort with reset while the first row is loading.
    clear_stats();
    ack_delay = 0; spike_vec = 16'h0005; spike_valid = 1'b1;
    pulse_start();
    budget = 0;
    while (!wemem_enable && budget < 200) begin
      @(negedge clk); #1;
      budget++;
    end
    check("abort.reached_load", int'(wemem_enable), 1);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk); #1;
    check("abort.busy", int'(busy), 0);
    check("abort.wemem_enable", int'(wemem_enable), 0);
    check("abort.row_req", int'(row_req), 0);
    check("abort.acc_en", int'(acc_en), 0);
    check("abort.spike_ready", int'(spike_ready), 0);
    check("abort.step_cnt", int'(step_cnt), 0);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    #1;
    check("abort.no_fire", n_fire, 0);
    check("abort.no_done", n_done, 0);
    $display("txn abort busy=%0d fires=%0d dones=%0d", busy, n_fire, n_done);
    run_test("after_abort", 16'h0005, 0, A_FETCH, 4, A_WE, A_LAT, A_RUN, 16'h0005, 1'b0);
    check_idle("after_abort");

    // start pokes while busy are ignored; a start in the cycle right after
    // done launches the next inference.
    run_test("poke", 16'h0005, 0, A_FETCH, 4, A_WE, A_LAT, A_RUN, 16'h0005, 1'b1);
    run_test("b2b", 16'h0005, 0, A_FETCH, 4, A_WE, A_LAT, A_RUN, 16'h0005, 1'b0);
    check_idle("b2b");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
